store_packer: RTL and testbench
===============================

// Module: store_packer
// PURPOSE
//   Store-side counterpart to the immediate/load extenders: narrows a 32-bit register
//   value to the byte lanes selected by sb/sh/sw and the address low bits.
//   Generates the lane byte-enables and queues stores in a small FIFO.
//   Drains the FIFO to data memory over a req/ack handshake.
//   Sits between the MEM stage and the data memory; the pipeline stalls on st_ready=0.
// PARAMETERS
//   DEPTH   4   FIFO entries; power of two, >=2
//   AW      32  address width
// PORTS
//   clk         in   1   rising-edge clock
//   reset_n     in   1   asynchronous active-low reset
//   st_valid    in   1   MEM stage presents a store this cycle
//   st_type     in   2   00=sw 01=sh 10=sb 11=reserved (treated as misaligned)
//   st_addr     in   AW  byte address from ALU
//   st_data     in   32  rt register value (unpacked, data in low bits)
//   st_ready    out  1   store accepted this cycle when st_valid&st_ready
//   align_err   out  1   one-cycle pulse: offered store was misaligned and dropped
//   mem_req     out  1   head entry valid toward memory
//   mem_addr    out  AW  word address {st_addr[AW-1:2],2'b00} of head entry
//   mem_wdata   out  32  lane-replicated write data of head entry
//   mem_be      out  4   byte enables of head entry, bit i = byte lane i
//   mem_ack     in   1   memory accepted head entry this cycle
//   empty       out  1   FIFO holds no entries (used for fence/syscall drain)
// BEHAVIOUR
//   Reset (async, reset_n=0): FIFO pointers and count cleared; mem_req=0, align_err=0,
//     empty=1, st_ready=1, mem_addr/mem_wdata/mem_be=0; entries in flight are discarded,
//     mem_req deasserts immediately without waiting for a clock edge.
//   Packing (combinational at push, stored in FIFO entry):
//     sw: wdata=st_data, be=4'b1111; requires st_addr[1:0]=00
//     sh: wdata={2{st_data[15:0]}}, be= st_addr[1] ? 4'b1100 : 4'b0011; requires st_addr[0]=0
//     sb: wdata={4{st_data[7:0]}}, be=4'b0001<<st_addr[1:0]
//     st_type=11 or alignment violated: no push, align_err=1 on the next cycle only.
//   Handshake, upstream: push when st_valid & st_ready & aligned.
//     st_ready = (count != DEPTH); no write-through when full, even if a pop coincides.
//   Handshake, downstream: mem_req = (count != 0); head fields are stable while mem_req=1 & !mem_ack.
//     Pop on mem_req & mem_ack; mem_ack while mem_req=0 is ignored.
//   Latency: a store pushed into an empty FIFO raises mem_req on the following cycle.
//     Throughput is 1 store/cycle with mem_ack held high.
//   Simultaneous push & pop (not full): count unchanged, both pointers advance.
//     Order is strictly FIFO.
//   Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits,
//     saturation is impossible by the rules above.
//   States (per FIFO occupancy): EMPTY (count=0) -> PARTIAL on push;
//     PARTIAL -> FULL on push at count=DEPTH-1 without pop;
//     FULL -> PARTIAL on pop; PARTIAL -> EMPTY on pop at count=1 without push.
//   empty = (count==0); combinational from registered state, no extra latency.
// TESTING
//   1 sw 0x12345678 @0x00000008 into empty FIFO, ack=1 -> next cycle mem_req=1,
//     addr=0x8, wdata=0x12345678, be=1111; popped that cycle, empty=1 after.
//   2 sb 0x000000AB @0x0000000D -> addr=0xC, wdata=0xABABABAB, be=0010;
//     sh 0xBEEF @0x12 -> addr=0x10, wdata=0xBEEFBEEF, be=1100.
//   3 mem_ack=0, push 4 stores -> st_ready=0 after the 4th; 5th offer held;
//     ack for 1 cycle -> one pop, st_ready=1, order preserved.
//   4 sh @0x3, sw @0x6, st_type=11 -> no push, align_err pulses once per offer, count unchanged.
//   5 FIFO with 3 entries, mem_req=1, reset_n=0 mid-cycle -> mem_req=0 immediately;
//     after release empty=1, no stale entry is re-issued.
//   6 Continuous push+pop with ack=1 for 10 stores -> count stays 1, pointers wrap,
//     outputs match input order.

Source files
------------

// File: rtl/store_packer.sv
`default_nettype none
// store_packer: narrows sb/sh/sw stores to lane-replicated data plus byte enables,
// queues them in a small FIFO and drains the head to data memory over req/ack.
module store_packer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          st_valid,
  input  logic [1:0]    st_type,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          align_err,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_ack,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_LAST = (PW+1)'(DEPTH - 1);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PARTIAL = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  localparam logic [1:0] T_SW = 2'b00;
  localparam logic [1:0] T_SH = 2'b01;
  localparam logic [1:0] T_SB = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          align_err_q;

  logic [31:0]   pk_wdata;
  logic [3:0]    pk_be;
  logic          pk_aligned;
  logic          push, pop;

  logic [AW-1:0] addr_mem_q  [DEPTH];
  logic [31:0]   wdata_mem_q [DEPTH];
  logic [3:0]    be_mem_q    [DEPTH];

  always_comb begin
    pk_wdata   = st_data;
    pk_be      = 4'b0000;
    pk_aligned = 1'b0;
    case (st_type)
      T_SW: begin
        pk_be      = 4'b1111;
        pk_aligned = (st_addr[1:0] == 2'b00);
      end
      T_SH: begin
        pk_wdata   = {2{st_data[15:0]}};
        pk_be      = st_addr[1] ? 4'b1100 : 4'b0011;
        pk_aligned = ~st_addr[0];
      end
      T_SB: begin
        pk_wdata   = {4{st_data[7:0]}};
        pk_be      = 4'b0001 << st_addr[1:0];
        pk_aligned = 1'b1;
      end
      default: pk_aligned = 1'b0;
    endcase
  end

  assign push    = st_valid & st_ready & pk_aligned;
  assign pop     = mem_req & mem_ack;
  assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_EMPTY;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      align_err_q <= st_valid & st_ready & ~pk_aligned;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage needs no reset: nothing is visible unless the occupancy says so.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q]  <= {st_addr[AW-1:2], 2'b00};
      wdata_mem_q[wr_ptr_q] <= pk_wdata;
      be_mem_q[wr_ptr_q]    <= pk_be;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY:   if (push) state_d = S_PARTIAL;
      S_PARTIAL: begin
        if (push && !pop && count_q == CNT_LAST)     state_d = S_FULL;
        else if (pop && !push && count_q == CNT_ONE) state_d = S_EMPTY;
      end
      S_FULL:    if (pop) state_d = S_PARTIAL;
      default:   state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    st_ready  = (state_q != S_FULL);
    mem_req   = (state_q != S_EMPTY);
    empty     = (state_q == S_EMPTY);
    align_err = align_err_q;
    mem_addr  = mem_req ? addr_mem_q[rd_ptr_q]  : '0;
    mem_wdata = mem_req ? wdata_mem_q[rd_ptr_q] : '0;
    mem_be    = mem_req ? be_mem_q[rd_ptr_q]    : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_store_packer.sv
`default_nettype none
// Randomized and directed bench for store_packer against a queue-based store model.
module tb_store_packer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          st_valid = 1'b0;
  logic [1:0]    st_type = 2'b00;
  logic [AW-1:0] st_addr = '0;
  logic [31:0]   st_data = '0;
  logic          st_ready, align_err, mem_req, empty;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack = 1'b0;

  store_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .align_err(align_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  be;
  } ent_t;

  ent_t mq[$];
  bit   m_err = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Store semantics from first principles: access size, natural alignment, lane offset.
  function automatic void pack(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                               output bit ok, output ent_t e);
    int sz;
    int mask;
    sz = (t == 2'd0) ? 4 : (t == 2'd1) ? 2 : (t == 2'd2) ? 1 : 0;
    ok = (sz != 0) && ((a % sz) == 0);
    e.a = a - (a % 4);
    if (sz == 4)      e.w = d;
    else if (sz == 2) e.w = d[15:0] * 32'h0001_0001;
    else              e.w = d[7:0]  * 32'h0101_0101;
    mask = ((1 << sz) - 1) << (a % 4);
    e.be = mask[3:0];
  endfunction

  always @(negedge reset_n) begin
    mq.delete();
    m_err = 1'b0;
  end

  always @(posedge clk) begin
    if (reset_n) begin
      bit   rdy, req, ok;
      ent_t e;
      rdy = (mq.size() < DEPTH);
      req = (mq.size() != 0);
      pack(st_type, st_addr, st_data, ok, e);
      m_err = st_valid && rdy && !ok;
      if (req && mem_ack) void'(mq.pop_front());
      if (st_valid && rdy && ok) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    chk("st_ready", 32'(st_ready), 32'(mq.size() < DEPTH));
    chk("mem_req", 32'(mem_req), 32'(mq.size() != 0));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("align_err", 32'(align_err), 32'(m_err));
    if (mq.size() != 0) begin
      chk("mem_addr", mem_addr, mq[0].a);
      chk("mem_wdata", mem_wdata, mq[0].w);
      chk("mem_be", 32'(mem_be), 32'(mq[0].be));
    end
  end

  // Inputs apply to the next rising edge; returns 1 time unit after that edge.
  task automatic cyc(input logic v, input logic [1:0] t, input logic [31:0] a,
                     input logic [31:0] d, input logic ack);
    st_valid = v; st_type = t; st_addr = a; st_data = d; mem_ack = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_align_err", 32'(align_err), 32'd0);
    chk("rst_fields", {mem_addr[27:0], mem_be}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // sw into empty FIFO with ack held high
    cyc(1, 2'd0, 32'h8, 32'h1234_5678, 1);
    chk("t1_req", 32'(mem_req), 32'd1);
    chk("t1_addr", mem_addr, 32'h8);
    chk("t1_wdata", mem_wdata, 32'h1234_5678);
    chk("t1_be", 32'(mem_be), 32'hF);
    cyc(0, 2'd0, 0, 0, 1);
    chk("t1_empty", 32'(empty), 32'd1);

    // sb then sh lane replication
    cyc(1, 2'd2, 32'hD, 32'h0000_00AB, 0);
    cyc(1, 2'd1, 32'h12, 32'h0000_BEEF, 0);
    chk("t2_sb_addr", mem_addr, 32'hC);
    chk("t2_sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("t2_sb_be", 32'(mem_be), 32'h2);
    cyc(0, 2'd0, 0, 0, 1);
    chk("t2_sh_addr", mem_addr, 32'h10);
    chk("t2_sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("t2_sh_be", 32'(mem_be), 32'hC);
    cyc(0, 2'd0, 0, 0, 1);
    chk("t2_empty", 32'(empty), 32'd1);

    // fill to full, offer held, single ack frees one slot
    for (int i = 0; i < 4; i++) cyc(1, 2'd0, 32'h100 + 4 * i, 32'hA0 + i, 0);
    chk("t3_full_ready", 32'(st_ready), 32'd0);
    cyc(1, 2'd0, 32'h110, 32'hA4, 0);
    chk("t3_held_ready", 32'(st_ready), 32'd0);
    chk("t3_head", mem_addr, 32'h100);
    cyc(1, 2'd0, 32'h110, 32'hA4, 1);
    chk("t3_ready_after_pop", 32'(st_ready), 32'd1);
    chk("t3_next_head", mem_addr, 32'h104);
    cyc(1, 2'd0, 32'h110, 32'hA4, 0);
    chk("t3_refull", 32'(st_ready), 32'd0);
    for (int i = 0; i < 4; i++) cyc(0, 2'd0, 0, 0, 1);
    chk("t3_empty", 32'(empty), 32'd1);

    // misaligned and reserved stores are dropped with a one-cycle pulse each
    cyc(1, 2'd1, 32'h3, 32'h1111, 0);
    chk("t4_err_sh", 32'(align_err), 32'd1);
    cyc(1, 2'd0, 32'h6, 32'h2222, 0);
    chk("t4_err_sw", 32'(align_err), 32'd1);
    cyc(1, 2'd3, 32'h0, 32'h3333, 0);
    chk("t4_err_rsv", 32'(align_err), 32'd1);
    chk("t4_empty", 32'(empty), 32'd1);
    cyc(0, 2'd0, 0, 0, 0);
    chk("t4_err_clear", 32'(align_err), 32'd0);

    // asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++) cyc(1, 2'd0, 32'h200 + 4 * i, 32'hC0 + i, 0);
    cyc(0, 2'd0, 0, 0, 0);
    chk("t5_req_before", 32'(mem_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_req_async", 32'(mem_req), 32'd0);
    chk("t5_empty_async", 32'(empty), 32'd1);
    chk("t5_addr_async", mem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 2'd0, 0, 0, 1);
    chk("t5_no_stale", 32'(mem_req), 32'd0);

    // streaming with ack held high keeps one entry resident
    for (int i = 0; i < 10; i++) begin
      cyc(1, 2'd0, $urandom & 32'hFFFF_FFFC, $urandom, 1);
      chk("t6_req", 32'(mem_req), 32'd1);
    end
    cyc(0, 2'd0, 0, 0, 1);
    chk("t6_empty", 32'(empty), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] t;
      t = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cyc(($urandom_range(0, 3) != 0), t, $urandom, $urandom, ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 2'd0, 0, 0, 1);
    chk("final_empty", 32'(empty), 32'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
